// File: rtl/aes_cipher_core_if.sv
// Request/response and key-schedule bundle between a requester, aes_cipher_core and the round-key generator.
// Handshake: start is taken only while the core is idle (busy=0); busy stays high through the done cycle.
interface aes_cipher_core_if;
  logic         start;
  logic [127:0] pt;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [127:0] ct;
  logic [127:0] ks_key;
  logic         ks_sel;
  logic         ks_rd;
  logic [127:0] rk;
  logic [2:0]   dbg_state;

  modport slave (
    input  start, pt, key, rk,
    output busy, done, ct, ks_key, ks_sel, ks_rd, dbg_state
  );

  modport master (
    output start, pt, key, rk,
    input  busy, done, ct, ks_key, ks_sel, ks_rd, dbg_state
  );
endinterface

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: one round per cycle, round keys streamed from an external
// Keyexpansion block steered through ks_sel/ks_rd.
module aes_cipher_core #(
  parameter int NR = 10
) (
  input  logic              CLK,
  input  logic              RST,
  aes_cipher_core_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  // Forward S-box, byte 0x00 in the top eight bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_rnd;
  logic [127:0] r_pt_q;
  logic [127:0] r_st;
  logic [127:0] r_ct;
  logic [127:0] r_ks_key;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_round;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes and ShiftRows fused: output byte (row r, col c) takes input column (c+r)%4.
  always_comb begin
    w_sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[127-8*(4*c+r) -: 8] = sbox(r_st[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
  end

  always_comb begin
    w_mc = '0;
    for (int c = 0; c < 4; c++) begin
      w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
    end
  end

  assign w_round = ((r_rnd == LAST_RND) ? w_sr : w_mc) ^ bus.rk;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_LOAD;
      S_LOAD:  w_next = S_INIT;
      S_INIT:  w_next = S_ROUND;
      S_ROUND: if (r_rnd == LAST_RND) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rnd    <= '0;
      r_pt_q   <= '0;
      r_st     <= '0;
      r_ct     <= '0;
      r_ks_key <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pt_q   <= bus.pt;
            r_ks_key <= bus.key;
          end
        end
        S_INIT: begin
          r_st  <= r_pt_q ^ bus.rk;
          r_rnd <= 4'd1;
        end
        S_ROUND: begin
          if (r_rnd == LAST_RND) begin
            r_ct <= w_round;
          end else begin
            r_st  <= w_round;
            r_rnd <= r_rnd + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Generator strobes come from registered state only, so the key stream is one cycle ahead of use.
  assign bus.ks_sel    = (r_state == S_LOAD);
  assign bus.ks_rd     = (r_state == S_INIT) || ((r_state == S_ROUND) && (r_rnd < LAST_RND));
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.ct        = r_ct;
  assign bus.ks_key    = r_ks_key;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed FIPS-197 vectors against aes_cipher_core with a behavioural round-key generator attached.
module tb_aes_cipher_core;

  localparam logic [2047:0] SBOX_TB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk;
  logic rst;
  aes_cipher_core_if bus();

  aes_cipher_core #(.NR(10)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sel_cnt = 0;
  int rd_cnt  = 0;
  int g_cnt   = 0;
  logic [127:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- round-key generator model ----------------
  function automatic logic [7:0] sbox_tb(input logic [7:0] b);
    logic [2047:0] t;
    logic [10:0]   idx;
    t   = SBOX_TB;
    idx = {~b, 3'b000};
    return t[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input int i);
    case (i)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input int i);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox_tb(w3[23:16]) ^ rcon(i), sbox_tb(w3[15:8]), sbox_tb(w3[7:0]), sbox_tb(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always @(posedge clk) begin
    if (bus.ks_sel) begin
      bus.rk <= bus.ks_key;
      g_cnt  <= 0;
    end else if (bus.ks_rd) begin
      bus.rk <= key_next(bus.rk, g_cnt + 1);
      g_cnt  <= g_cnt + 1;
    end
  end

  // ---------------- generator protocol monitor ----------------
  always @(negedge clk) begin
    if (!bus.busy) begin
      sel_cnt = 0;
      rd_cnt  = 0;
    end else begin
      if (bus.ks_sel) sel_cnt++;
      if (bus.ks_rd)  rd_cnt++;
      check("ks_sel_rd_overlap", 128'(bus.ks_sel & bus.ks_rd), 128'd0);
      if (bus.done) begin
        check("ks_rd_cycles", 128'(rd_cnt), 128'd10);
        check("ks_sel_cycles", 128'(sel_cnt), 128'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call right after the accept edge; counts cycles until done and scores ct.
  task automatic wait_done(input string tag, input bit jitter_pt);
    int lat;
    bit busy_ok;
    logic [127:0] exp;
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.busy) busy_ok = 1'b0;
      if (jitter_pt && !bus.done) bus.pt = {$urandom, $urandom, $urandom, $urandom};
    end while (!bus.done && lat < 40);
    exp = exp_q.pop_front();
    check({tag, "_latency"}, 128'(lat), 128'd13);
    check({tag, "_busy_held"}, 128'(busy_ok), 128'd1);
    check({tag, "_ct"}, bus.ct, exp);
  endtask

  task automatic encrypt(input string tag, input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = k;
    bus.pt    = p;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.key   = '0;
    bus.pt    = '0;
    check({tag, "_ks_key"}, bus.ks_key, k);
    wait_done(tag, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit saw_done;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.pt    = '0;
    bus.key   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   128'(bus.busy),   128'd0);
    check("rst_done",   128'(bus.done),   128'd0);
    check("rst_ct",     bus.ct,           128'd0);
    check("rst_ks_sel", 128'(bus.ks_sel), 128'd0);
    check("rst_ks_rd",  128'(bus.ks_rd),  128'd0);
    check("rst_ks_key", bus.ks_key,       128'd0);
    check("rst_state",  128'(bus.dbg_state), 128'd0);
    rst = 1'b0;

    encrypt("appB", KEY_B, PT_B, CT_B);
    encrypt("appC1", KEY_C, PT_C, CT_C);
    encrypt("zero", '0, '0, CT_Z);
    encrypt("appB_b2b", KEY_B, PT_B, CT_B);

    // start held high with a wandering pt: only the captured pt counts
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = KEY_C;
    bus.pt    = PT_C;
    exp_q.push_back(CT_C);
    @(posedge clk);
    #1;
    wait_done("hold_first", 1'b1);
    bus.key = KEY_B;
    bus.pt  = PT_B;
    exp_q.push_back(CT_B);
    @(negedge clk);
    check("hold_idle_gap_busy", 128'(bus.busy), 128'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("hold_second_ks_key", bus.ks_key, KEY_B);
    wait_done("hold_second", 1'b0);

    // reset during round 5
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = KEY_B;
    bus.pt    = PT_B;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_in_round", 128'(bus.dbg_state), 128'd3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",   128'(bus.busy),   128'd0);
    check("mid_rst_ct",     bus.ct,           128'd0);
    check("mid_rst_ks_rd",  128'(bus.ks_rd),  128'd0);
    check("mid_rst_ks_sel", 128'(bus.ks_sel), 128'd0);
    check("mid_rst_done",   128'(bus.done),   128'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("mid_rst_no_done", 128'(saw_done), 128'd0);
    encrypt("after_rst_appC1", KEY_C, PT_C, CT_C);

    // reset and start together: request dropped
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.key   = KEY_B;
    bus.pt    = PT_B;
    @(negedge clk);
    check("rst_start_busy",  128'(bus.busy),   128'd0);
    check("rst_start_state", 128'(bus.dbg_state), 128'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_start_dropped", 128'(bus.busy), 128'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
